// File: rtl/hus_dac_tx_pkg.sv
`default_nettype none
// ============================================================================
// hus_dac_tx_pkg : shared defaults and channel indices for the HUS DAC path
// Rev 1.0
// ============================================================================
package hus_dac_tx_pkg;

   localparam int HUS_DW      = 16;
   localparam int HUS_BCK_DIV = 4;
   localparam int HUS_NUM_CH  = 2;
   localparam int CH_L        = 0;
   localparam int CH_R        = 1;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int hus_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hus_dac_tx_if.sv
`default_nettype none
// ============================================================================
// hus_dac_tx_if : sample write strobe side plus serial DAC and status outputs
// Rev 1.0
// ============================================================================
interface hus_dac_tx_if
   import hus_dac_tx_pkg::*;
#(
   parameter int DW = HUS_DW
) ();

   logic          enable;
   logic [1:0]    dac_we;
   logic [DW-1:0] dac_data;
   logic          dac_bck;
   logic          dac_ws;
   logic          dac_dat;
   logic          frame_stb;
   logic [1:0]    underrun;
   logic [1:0]    overrun;

   modport master (
      output enable, dac_we, dac_data,
      input  dac_bck, dac_ws, dac_dat, frame_stb, underrun, overrun
   );

   modport slave (
      input  enable, dac_we, dac_data,
      output dac_bck, dac_ws, dac_dat, frame_stb, underrun, overrun
   );

endinterface
`default_nettype wire

// File: rtl/hus_dac_tx_clkgen.sv
`default_nettype none
// ============================================================================
// hus_dac_tx_clkgen : BCK divider and falling-edge shift strobe, enable gated
// Rev 1.0
// ============================================================================
module hus_dac_tx_clkgen
   import hus_dac_tx_pkg::*;
#(
   parameter int BCK_DIV = HUS_BCK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   output logic o_bck,
   output logic o_shift_ev
);

   localparam int                 c_div_w    = hus_cnt_w(BCK_DIV);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCK_DIV - 1);

   logic [c_div_w-1:0] r_div_cnt;
   logic               r_bck;
   logic               w_tc;

   assign w_tc = (r_div_cnt == c_div_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_bck     <= 1'b0;
      end else if (!i_enable) begin
         r_div_cnt <= '0;
         r_bck     <= 1'b0;
      end else if (w_tc) begin
         r_div_cnt <= '0;
         r_bck     <= ~r_bck;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   assign o_bck = r_bck;

   // Combinational so the shifter updates on the very edge where BCK falls.
   assign o_shift_ev = i_enable & w_tc & r_bck;

endmodule
`default_nettype wire

// File: rtl/hus_dac_tx.sv
`default_nettype none
// ============================================================================
// hus_dac_tx : holds L/R samples and serialises them as I2S / left-justified
// Rev 1.0
// ============================================================================
module hus_dac_tx
   import hus_dac_tx_pkg::*;
#(
   parameter int BCK_DIV   = HUS_BCK_DIV,
   parameter int DW        = HUS_DW,
   parameter int I2S_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   hus_dac_tx_if.slave bus
);

   localparam int                 c_frame_bits = 2 * DW;
   localparam int                 c_cnt_w      = hus_cnt_w(c_frame_bits);
   localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(c_frame_bits - 1);
   localparam logic [c_cnt_w-1:0] c_load_cnt   = c_cnt_w'(I2S_DELAY);
   localparam logic [c_cnt_w-1:0] c_ws_cnt     = c_cnt_w'(DW);

   logic                    w_bck;
   logic                    w_shift_ev;
   logic                    w_load;
   logic [c_cnt_w-1:0]      w_bit_nxt;
   logic [c_cnt_w-1:0]      r_bit_cnt;
   logic                    r_ws;
   logic [c_frame_bits-1:0] r_sh;
   logic                    r_frame_stb;
   logic [DW-1:0]           r_hold [HUS_NUM_CH];
   logic [1:0]              r_pend;
   logic [1:0]              r_underrun;
   logic [1:0]              r_overrun;

   hus_dac_tx_clkgen #(
      .BCK_DIV    (BCK_DIV)
   ) u_clkgen (
      .clk        (clk),
      .rst        (reset),
      .i_enable   (bus.enable),
      .o_bck      (w_bck),
      .o_shift_ev (w_shift_ev)
   );

   assign w_bit_nxt = (r_bit_cnt == c_cnt_last) ? '0 : r_bit_cnt + 1'b1;
   assign w_load    = w_shift_ev & (w_bit_nxt == c_load_cnt);

   // A write landing on the load edge is kept pending for the next frame,
   // while the shifter still takes the previous hold value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold[CH_L] <= '0;
         r_hold[CH_R] <= '0;
         r_pend       <= '0;
         r_underrun   <= '0;
         r_overrun    <= '0;
      end else begin
         for (int ch = 0; ch < HUS_NUM_CH; ch++) begin
            if (bus.dac_we[ch]) begin
               r_hold[ch] <= bus.dac_data;
            end
            if (w_load) begin
               r_pend[ch]     <= bus.dac_we[ch];
               r_underrun[ch] <= ~r_pend[ch] & ~bus.dac_we[ch];
               r_overrun[ch]  <= 1'b0;
            end else begin
               r_underrun[ch] <= 1'b0;
               r_overrun[ch]  <= r_pend[ch] & bus.dac_we[ch];
               if (bus.dac_we[ch]) begin
                  r_pend[ch] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt   <= '0;
         r_ws        <= 1'b0;
         r_sh        <= '0;
         r_frame_stb <= 1'b0;
      end else if (!bus.enable) begin
         r_bit_cnt   <= '0;
         r_ws        <= 1'b0;
         r_sh        <= '0;
         r_frame_stb <= 1'b0;
      end else begin
         r_frame_stb <= w_load;
         if (w_shift_ev) begin
            r_bit_cnt <= w_bit_nxt;
            r_ws      <= (w_bit_nxt >= c_ws_cnt);
            if (w_load) begin
               r_sh <= {r_hold[CH_L], r_hold[CH_R]};
            end else begin
               r_sh <= {r_sh[c_frame_bits-2:0], 1'b0};
            end
         end
      end
   end

   assign bus.dac_bck   = w_bck;
   assign bus.dac_ws    = r_ws;
   assign bus.dac_dat   = r_sh[c_frame_bits-1];
   assign bus.frame_stb = r_frame_stb;
   assign bus.underrun  = r_underrun;
   assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hus_dac_tx.sv
`default_nettype none
// ============================================================================
// tb_hus_dac_tx : directed + random bench for hus_dac_tx (I2S and left-justified)
// Rev 1.0
// ============================================================================
module tb_hus_dac_tx;
   import hus_dac_tx_pkg::*;

   localparam int DW      = 16;
   localparam int BCK_DIV = 2;
   localparam int FB      = 2 * DW;
   localparam int BCK_CLK = 2 * BCK_DIV;

   logic          clk    = 1'b0;
   logic          reset  = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    we     = 2'b00;
   logic [DW-1:0] data   = '0;

   always #5 clk = ~clk;

   hus_dac_tx_if #(.DW(DW)) bus0 ();
   hus_dac_tx_if #(.DW(DW)) bus1 ();

   assign bus0.enable   = enable;
   assign bus0.dac_we   = we;
   assign bus0.dac_data = data;
   assign bus1.enable   = enable;
   assign bus1.dac_we   = we;
   assign bus1.dac_data = data;

   hus_dac_tx #(.BCK_DIV(BCK_DIV), .DW(DW), .I2S_DELAY(1)) dut_i2s (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   hus_dac_tx #(.BCK_DIV(BCK_DIV), .DW(DW), .I2S_DELAY(0)) dut_lj (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   logic       obs_bck [2];
   logic       obs_ws  [2];
   logic       obs_dat [2];
   logic       obs_stb [2];
   logic [1:0] obs_un  [2];
   logic [1:0] obs_ov  [2];

   assign obs_bck[0] = bus0.dac_bck;
   assign obs_ws[0]  = bus0.dac_ws;
   assign obs_dat[0] = bus0.dac_dat;
   assign obs_stb[0] = bus0.frame_stb;
   assign obs_un[0]  = bus0.underrun;
   assign obs_ov[0]  = bus0.overrun;
   assign obs_bck[1] = bus1.dac_bck;
   assign obs_ws[1]  = bus1.dac_ws;
   assign obs_dat[1] = bus1.dac_dat;
   assign obs_stb[1] = bus1.frame_stb;
   assign obs_un[1]  = bus1.underrun;
   assign obs_ov[1]  = bus1.overrun;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference: time since enable drives BCK/WS/bit position arithmetically.
   int            m_t      [2];
   logic [DW-1:0] m_hold   [2][2];
   logic [1:0]    m_pend   [2];
   logic [FB-1:0] m_word   [2];
   int            m_load_f [2];
   logic          m_stb    [2];
   logic [1:0]    m_un     [2];
   logic [1:0]    m_ov     [2];
   logic          prev_ws1 = 1'b0;

   function automatic int delay_of(input int k);
      return (k == 0) ? 1 : 0;
   endfunction

   function automatic bit load_next(input int k);
      int tn;
      tn = m_t[k] + 1;
      return enable && (tn % BCK_CLK == 0) && ((tn / BCK_CLK) % FB == delay_of(k));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_t[k]       = 0;
      m_hold[k][0] = '0;
      m_hold[k][1] = '0;
      m_pend[k]    = '0;
      m_word[k]    = '0;
      m_load_f[k]  = -1;
      m_stb[k]     = 1'b0;
      m_un[k]      = '0;
      m_ov[k]      = '0;
   endtask

   task automatic model_edge(input int k);
      bit            load;
      int            f;
      logic [FB-1:0] w_old;
      if (reset) begin
         model_reset(k);
         return;
      end
      if (enable) begin
         m_t[k]++;
      end else begin
         m_t[k]      = 0;
         m_load_f[k] = -1;
      end
      f     = m_t[k] / BCK_CLK;
      load  = enable && (m_t[k] % BCK_CLK == 0) && (f % FB == delay_of(k));
      w_old = {m_hold[k][CH_L], m_hold[k][CH_R]};
      m_stb[k] = load;
      for (int ch = 0; ch < 2; ch++) begin
         if (load) begin
            m_un[k][ch]   = !m_pend[k][ch] && !we[ch];
            m_ov[k][ch]   = 1'b0;
            m_pend[k][ch] = we[ch];
         end else begin
            m_un[k][ch]   = 1'b0;
            m_ov[k][ch]   = m_pend[k][ch] && we[ch];
            m_pend[k][ch] = m_pend[k][ch] || we[ch];
         end
         if (we[ch]) m_hold[k][ch] = data;
      end
      if (load) begin
         m_word[k]   = w_old;
         m_load_f[k] = f;
      end
   endtask

   task automatic check_outputs(input int k);
      int   f;
      int   age;
      logic e_dat;
      f     = m_t[k] / BCK_CLK;
      age   = f - m_load_f[k];
      e_dat = (m_load_f[k] >= 0 && age < FB) ? m_word[k][FB-1-age] : 1'b0;
      chk($sformatf("dut%0d_bck", k), 32'(obs_bck[k]), 32'((m_t[k] / BCK_DIV) % 2));
      chk($sformatf("dut%0d_ws", k),  32'(obs_ws[k]),  32'((f % FB) >= DW));
      chk($sformatf("dut%0d_dat", k), 32'(obs_dat[k]), 32'(e_dat));
      chk($sformatf("dut%0d_stb", k), 32'(obs_stb[k]), 32'(m_stb[k]));
      chk($sformatf("dut%0d_ur", k),  32'(obs_un[k]),  32'(m_un[k]));
      chk($sformatf("dut%0d_or", k),  32'(obs_ov[k]),  32'(m_ov[k]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_outputs(0);
      check_outputs(1);
      // Left-justified: the load coincides with WS falling.
      if (obs_stb[1]) begin
         chk("lj_ws_before_load", 32'(prev_ws1), 32'd1);
         chk("lj_ws_at_load", 32'(obs_ws[1]), 32'd0);
      end
      prev_ws1 = obs_ws[1];
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_bck%0d", tag, k), 32'(obs_bck[k]), 32'd0);
         chk($sformatf("%s_ws%0d", tag, k),  32'(obs_ws[k]),  32'd0);
         chk($sformatf("%s_dat%0d", tag, k), 32'(obs_dat[k]), 32'd0);
         chk($sformatf("%s_stb%0d", tag, k), 32'(obs_stb[k]), 32'd0);
         chk($sformatf("%s_ur%0d", tag, k),  32'(obs_un[k]),  32'd0);
         chk($sformatf("%s_or%0d", tag, k),  32'(obs_ov[k]),  32'd0);
      end
   endtask

   task automatic wait_stb(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!obs_stb[0] && n < 400);
      chk({tag, "_stb_seen"}, 32'(obs_stb[0]), 32'd1);
   endtask

   // Samples one bit per BCK period, starting on the load cycle.
   task automatic capture(output logic [FB-1:0] bits, output logic [FB-1:0] wsv);
      for (int i = 0; i < FB; i++) begin
         bits[FB-1-i] = obs_dat[0];
         wsv[FB-1-i]  = obs_ws[0];
         repeat (BCK_CLK) tick();
      end
   endtask

   initial begin
      logic [FB-1:0] bits;
      logic [FB-1:0] wsv;
      logic [DW-1:0] lv;
      logic [DW-1:0] rv;
      int            n;

      model_reset(0);
      model_reset(1);
      enable = 1'b1;
      #1 reset = 1'b1;
      #2;
      chk_zero("t1_in_reset");
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_zero("t1_after_release");

      // Basic frame: A5C3 / 1234
      enable = 1'b0;
      tick();
      we = 2'b01; data = 16'hA5C3;
      tick();
      we = 2'b10; data = 16'h1234;
      tick();
      we = 2'b00; enable = 1'b1;
      wait_stb("t2", n);
      chk("t2_first_load_clk", 32'(n), 32'(2 * BCK_DIV));
      capture(bits, wsv);
      chk("t2_bits", 32'(bits), 32'hA5C3_1234);
      chk("t2_ws", 32'(wsv), 32'h0001_FFFE);
      chk("t2_stb_128clk", 32'(obs_stb[0]), 32'd1);
      chk("t3_underrun", 32'(obs_un[0]), 32'd3);
      capture(bits, wsv);
      chk("t3_bits", 32'(bits), 32'hA5C3_1234);

      // Overrun on the left channel
      we = 2'b01; data = 16'h1111;
      tick();
      chk("t4_no_or_first", 32'(obs_ov[0]), 32'd0);
      data = 16'h2222;
      tick();
      chk("t4_or_left", 32'(obs_ov[0]), 32'd1);
      we = 2'b00;
      tick();
      chk("t4_or_single", 32'(obs_ov[0]), 32'd0);
      wait_stb("t4", n);
      capture(bits, wsv);
      chk("t4_bits", 32'(bits), 32'h2222_1234);

      // Right write on the load edge
      n = 0;
      while (!load_next(0) && n < 400) begin
         tick();
         n++;
      end
      chk("t5_load_found", 32'(load_next(0)), 32'd1);
      we = 2'b10; data = 16'hBEEF;
      tick();
      we = 2'b00;
      chk("t5_stb", 32'(obs_stb[0]), 32'd1);
      chk("t5_no_or", 32'(obs_ov[0]), 32'd0);
      chk("t5_no_ur_right", 32'(obs_un[0][CH_R]), 32'd0);
      capture(bits, wsv);
      chk("t5_old_right", 32'(bits[DW-1:0]), 32'h1234);
      chk("t5_next_no_ur_right", 32'(obs_un[0][CH_R]), 32'd0);
      capture(bits, wsv);
      chk("t5_new_right", 32'(bits), 32'h2222_BEEF);

      // Async reset at bit_cnt = 9
      repeat (8 * BCK_CLK) tick();
      reset = 1'b1;
      #2;
      chk_zero("t6_async_reset");
      tick();
      tick();
      reset = 1'b0;
      lv = DW'($urandom);
      rv = DW'($urandom);
      we = 2'b01; data = lv;
      tick();
      we = 2'b10; data = rv;
      tick();
      we = 2'b00;
      wait_stb("t6_rst", n);
      chk("t6_rst_restart_clk", 32'(n), 32'd2);
      capture(bits, wsv);
      chk("t6_rst_bits", 32'(bits), {lv, rv});
      chk("t6_rst_ws_at_msb", 32'(wsv[FB-1]), 32'd0);

      // Enable dropped inside the right slot
      repeat (20 * BCK_CLK) tick();
      chk("t6_ws_high_before_drop", 32'(obs_ws[0]), 32'd1);
      enable = 1'b0;
      tick();
      chk("t6_dis_bck", 32'(obs_bck[0]), 32'd0);
      chk("t6_dis_ws", 32'(obs_ws[0]), 32'd0);
      chk("t6_dis_dat", 32'(obs_dat[0]), 32'd0);
      repeat (5) tick();
      enable = 1'b1;
      wait_stb("t6_en", n);
      chk("t6_en_restart_clk", 32'(n), 32'(2 * BCK_DIV));

      // Random writes with occasional enable toggles
      for (int i = 0; i < 3000; i++) begin
         we   = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
         data = DW'($urandom);
         if ($urandom_range(0, 699) == 0) enable = ~enable;
         tick();
      end
      we = 2'b00;
      enable = 1'b1;
      repeat (2 * FB * BCK_CLK) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
